// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared definitions for the countdown timer and stopwatch.
//                It holds the timer state encoding, the tenths-per-second
//                constant, the default prescale and a tenths clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;

    localparam int TENTHS_PER_SEC      = 10;
    localparam int DEFAULT_TICK_CYCLES = 5000000;

    localparam logic [3:0] MAX_TENTH = 4'(TENTHS_PER_SEC - 1);

    // Saturate a raw tenths value to the displayable range 0..9.
    function automatic logic [3:0] clamp_tenth(input logic [3:0] t);
        return (t > MAX_TENTH) ? MAX_TENTH : t;
    endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides clk down to a one-cycle tick every TICK_CYCLES
//                enabled cycles. When enable is low the count holds its
//                value, so a paused timer resumes mid-interval.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                enable       - count this cycle (low = hold)
//                clear        - restart the interval from zero
//                tick         - high on the enabled cycle that ends an
//                               interval
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W        = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] c_LAST_COUNT = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == c_LAST_COUNT);
    assign tick      = enable && w_at_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_at_last ? '0 : r_count + 1'b1;
        end
    end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer
//  Description : Loadable seconds/tenths down-counter. It decrements once per
//                prescaled tick while running. On reaching 0.0 it raises a
//                level expired flag and a one-cycle done pulse. The output
//                format matches the stopwatch so both can share a display mux.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                load, load_sec,
//                load_tenth          - capture a (clamped) preset, go IDLE
//                start, pause        - run / resume and pause controls
//                seconds, m_seconds  - remaining seconds and tenths
//                running, expired    - state RUN / state EXPIRED
//                done                - one-cycle pulse on entering EXPIRED
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import timer_pkg::*;
#(
    parameter int TICK_CYCLES = DEFAULT_TICK_CYCLES,
    parameter int MAX_SEC     = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [9:0]  load_sec,
    input  logic [3:0]  load_tenth,
    input  logic        start,
    input  logic        pause,
    output logic [31:0] seconds,
    output logic [31:0] m_seconds,
    output logic        running,
    output logic        expired,
    output logic        done
);

    localparam logic [9:0] c_MAX_SEC = 10'(MAX_SEC);

    timer_state_t r_state, w_state_nxt;
    logic [9:0]   r_sec,   w_sec_nxt;
    logic [3:0]   r_tenth, w_tenth_nxt;
    logic         r_done,  w_done_nxt;

    logic         w_nonzero;
    logic         w_pre_en;
    logic         w_pre_clr;
    logic         w_tick;

    assign w_nonzero = (r_sec != 10'd0) || (r_tenth != 4'd0);

    // The prescaler counts only in RUN with no higher-priority control
    // present. A pause on a tick edge therefore freezes the count at its
    // last value, so the tick lands on the first enabled cycle after resume.
    assign w_pre_en  = (r_state == RUN) && !load && !pause;
    assign w_pre_clr = load || ((r_state == IDLE) && start && !pause && w_nonzero);

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .enable (w_pre_en),
        .clear  (w_pre_clr),
        .tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sec   <= 10'd0;
            r_tenth <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sec   <= w_sec_nxt;
            r_tenth <= w_tenth_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec;
        w_tenth_nxt = r_tenth;
        w_done_nxt  = 1'b0;

        if (load) begin
            w_sec_nxt   = (load_sec > c_MAX_SEC) ? c_MAX_SEC : load_sec;
            w_tenth_nxt = clamp_tenth(load_tenth);
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // A zero preset cannot be started; pause outranks start.
                    if (start && !pause && w_nonzero) begin
                        w_state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        w_state_nxt = PAUSED;
                    end else if (w_tick) begin
                        if (r_tenth != 4'd0) begin
                            w_tenth_nxt = r_tenth - 4'd1;
                        end else if (r_sec != 10'd0) begin
                            w_sec_nxt   = r_sec - 10'd1;
                            w_tenth_nxt = MAX_TENTH;
                        end
                        if ((w_sec_nxt == 10'd0) && (w_tenth_nxt == 4'd0)) begin
                            w_state_nxt = EXPIRED;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        w_state_nxt = RUN;
                    end
                end
                EXPIRED: begin
                    // Held at 0.0 until load or rst.
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign seconds   = {22'd0, r_sec};
    assign m_seconds = {28'd0, r_tenth};
    assign running   = (r_state == RUN);
    assign expired   = (r_state == EXPIRED);
    assign done      = r_done;

endmodule : countdown_timer
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer
//  Description : Self-checking bench for countdown_timer with TICK_CYCLES=4.
//                A reference model tracks the remaining time as a single
//                tenths count, plus a mode and a tick phase, and every
//                output is compared against it after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int TICK = 4;
    localparam int MAXS = 999;

    logic        clk = 1'b0;
    logic        rst, load, start, pause;
    logic [9:0]  load_sec;
    logic [3:0]  load_tenth;
    logic [31:0] seconds, m_seconds;
    logic        running, expired, done;

    always #5 clk = ~clk;

    countdown_timer #(
        .TICK_CYCLES (TICK),
        .MAX_SEC     (MAXS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_sec   (load_sec),
        .load_tenth (load_tenth),
        .start      (start),
        .pause      (pause),
        .seconds    (seconds),
        .m_seconds  (m_seconds),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Reference model: remaining time in tenths, mode 0=idle 1=run
    // 2=paused 3=expired, and cycles elapsed in the current tick interval.
    int m_val   = 0;
    int m_mode  = 0;
    int m_phase = 0;
    int m_done  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        m_done = 0;
        if (rst) begin
            m_val = 0; m_mode = 0; m_phase = 0;
        end else if (load) begin
            m_val   = ((load_sec > MAXS) ? MAXS : int'(load_sec)) * 10
                    + ((load_tenth > 9) ? 9 : int'(load_tenth));
            m_mode  = 0;
            m_phase = 0;
        end else begin
            case (m_mode)
                0: if (start && !pause && m_val > 0) begin
                       m_mode = 1; m_phase = 0;
                   end
                1: if (pause) begin
                       m_mode = 2;
                   end else if (m_phase == TICK - 1) begin
                       m_phase = 0;
                       if (m_val > 0) m_val = m_val - 1;
                       if (m_val == 0) begin
                           m_mode = 3; m_done = 1;
                       end
                   end else begin
                       m_phase++;
                   end
                2: if (start && !pause) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "/sec"},     seconds,   32'(m_val / 10));
        check({tag, "/tenth"},   m_seconds, 32'(m_val % 10));
        check({tag, "/running"}, {31'd0, running}, 32'(m_mode == 1));
        check({tag, "/expired"}, {31'd0, expired}, 32'(m_mode == 3));
        check({tag, "/done"},    {31'd0, done},    32'(m_done));
    endtask

    task automatic step(input logic r, input logic ld, input logic st, input logic pa,
                        input logic [9:0] ls, input logic [3:0] lt, input string tag);
        rst = r; load = ld; start = st; pause = pa;
        load_sec = ls; load_tenth = lt;
        cycle(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 10'd0, 4'd0, tag);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_sec = 10'd0; load_tenth = 4'd0;

        // Reset, then a start with 0.0 loaded is ignored.
        step(1, 0, 0, 0, 10'd0, 4'd0, "reset");
        step(1, 0, 0, 0, 10'd0, 4'd0, "reset");
        check("reset_sec", seconds, 32'd0);
        check("reset_run", {31'd0, running}, 32'd0);
        step(0, 0, 1, 0, 10'd0, 4'd0, "zero_start");
        idle(3, "zero_idle");
        check("zero_start_run",  {31'd0, running}, 32'd0);
        check("zero_start_done", {31'd0, done},    32'd0);

        // Basic countdown of 1.2: twelve ticks, 48 cycles.
        step(0, 1, 0, 0, 10'd1, 4'd2, "basic_load");
        step(0, 0, 1, 0, 10'd0, 4'd0, "basic_start");
        idle(4, "basic_run");
        check("basic_first_tick", m_seconds, 32'd1);
        idle(43, "basic_run");
        check("basic_pre_expire", {31'd0, expired}, 32'd0);
        idle(1, "basic_expire");
        check("basic_expired", {31'd0, expired}, 32'd1);
        check("basic_done",    {31'd0, done},    32'd1);
        idle(1, "basic_after");
        check("basic_done_once", {31'd0, done}, 32'd0);
        idle(20, "basic_hold");
        check("basic_hold_zero", m_seconds, 32'd0);

        // Pause at tenths 0.4, prescaler 1; resume ticks 3 cycles later.
        step(0, 1, 0, 0, 10'd0, 4'd5, "pr_load");
        step(0, 0, 1, 0, 10'd0, 4'd0, "pr_start");
        idle(5, "pr_run");
        step(0, 0, 0, 1, 10'd0, 4'd0, "pr_pause");
        check("pr_paused_val", m_seconds, 32'd4);
        idle(10, "pr_frozen");
        check("pr_frozen_val", m_seconds, 32'd4);
        step(0, 0, 1, 0, 10'd0, 4'd0, "pr_resume");
        idle(2, "pr_run2");
        check("pr_before_tick", m_seconds, 32'd4);
        idle(1, "pr_tick");
        check("pr_after_tick", m_seconds, 32'd3);
        idle(12, "pr_finish");
        check("pr_expired", {31'd0, expired}, 32'd1);

        // Clamping of oversize presets.
        step(0, 1, 0, 0, 10'd1023, 4'd15, "clamp");
        check("clamp_sec",   seconds,   32'd999);
        check("clamp_tenth", m_seconds, 32'd9);

        // load beats pause and start; pause beats start when paused.
        step(0, 1, 0, 0, 10'd2, 4'd0, "prio_load");
        step(0, 0, 1, 0, 10'd0, 4'd0, "prio_start");
        idle(3, "prio_run");
        step(0, 1, 1, 1, 10'd0, 4'd7, "prio_all");
        check("prio_all_val", m_seconds, 32'd7);
        check("prio_all_run", {31'd0, running}, 32'd0);
        step(0, 0, 1, 0, 10'd0, 4'd0, "prio_start2");
        idle(2, "prio_run2");
        step(0, 0, 0, 1, 10'd0, 4'd0, "prio_pause");
        step(0, 0, 1, 1, 10'd0, 4'd0, "prio_ps");
        check("prio_ps_run", {31'd0, running}, 32'd0);
        step(0, 0, 1, 0, 10'd0, 4'd0, "prio_resume");
        check("prio_resume_run", {31'd0, running}, 32'd1);

        // Reset in the middle of a run.
        step(0, 1, 0, 0, 10'd5, 4'd0, "mid_load");
        step(0, 0, 1, 0, 10'd0, 4'd0, "mid_start");
        idle(6, "mid_run");
        check("mid_val", m_seconds, 32'd9);
        step(1, 0, 0, 0, 10'd0, 4'd0, "mid_rst");
        check("mid_rst_sec", seconds,   32'd0);
        check("mid_rst_run", {31'd0, running}, 32'd0);

        // EXPIRED ignores start; a new load restarts counting.
        step(0, 1, 0, 0, 10'd0, 4'd1, "exp_load");
        step(0, 0, 1, 0, 10'd0, 4'd0, "exp_start");
        idle(4, "exp_run");
        step(0, 0, 1, 0, 10'd0, 4'd0, "exp_start_ign");
        check("exp_start_ign", {31'd0, expired}, 32'd1);
        step(0, 1, 0, 0, 10'd0, 4'd3, "exp_reload");
        step(0, 0, 1, 0, 10'd0, 4'd0, "exp_restart");
        idle(12, "exp_rerun");
        check("exp_rerun_exp", {31'd0, expired}, 32'd1);

        // Randomized traffic; small presets so expiry happens often.
        for (int i = 0; i < 4000; i++) begin
            automatic int r = $urandom_range(0, 999);
            automatic logic [9:0] ls = ($urandom_range(0, 19) == 0)
                                     ? 10'($urandom_range(990, 1023))
                                     : 10'($urandom_range(0, 2));
            automatic logic [3:0] lt = 4'($urandom_range(0, 15));
            step(r < 5, (r >= 5) && (r < 35),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 ls, lt, "rand");
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_countdown_timer
`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counting timer; the counterpart of the up-counting stopwatch in the same calculator/stopwatch design.
- Holds a preset in seconds and tenths of a second and decrements it once per tenth-second tick while running.
- Raises an expired flag and a one-cycle done pulse on reaching 0.0.
- Output format is identical to the stopwatch (32-bit seconds, 32-bit tenths), so both blocks feed the same display path through one mux.

Parameters:
- TICK_CYCLES, 5000000, clock cycles per tenth-second tick (50 MHz / 10); must be >= 2.
- MAX_SEC, 999, largest loadable seconds value; larger loads clamp to this.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe: capture load_sec/load_tenth.
- load_sec  in  10  preset seconds, 0..MAX_SEC.
- load_tenth  in  4  preset tenths, 0..9.
- start  in  1  start or resume.
- pause  in  1  pause counting.
- seconds  out  32  remaining whole seconds.
- m_seconds  out  32  remaining tenths, 0..9.
- running  out  1  high while state is RUN.
- expired  out  1  level, high while state is EXPIRED.
- done  out  1  one-cycle pulse on the transition into EXPIRED.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst sampled high on an edge): state IDLE, seconds=0, m_seconds=0, prescaler=0, running=0, expired=0, done=0. rst overrides all other inputs.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- Input priority per edge: rst > load > pause > start.
- load (any state):
  - seconds <= min(load_sec, MAX_SEC); m_seconds <= min(load_tenth, 9).
  - prescaler <= 0; state <= IDLE; expired cleared.
- IDLE + start:
  - If the value is nonzero: state <= RUN with prescaler 0.
  - If the value is 0.0: start is ignored and the block stays in IDLE. No done pulse.
- RUN:
  - prescaler increments every cycle.
  - When prescaler == TICK_CYCLES-1: prescaler <= 0 and apply one tick.
  - The first decrement becomes visible TICK_CYCLES edges after the edge that sampled start.
- Tick rules:
  - If m_seconds > 0: m_seconds - 1.
  - Else if seconds > 0: seconds - 1 and m_seconds <= 9.
  - If the result is 0.0: state <= EXPIRED and done=1 for exactly that one cycle.
  - The counter never wraps below 0.0.
- RUN + pause: state <= PAUSED. The prescaler holds its value and is not cleared.
  - If pause and a tick fall on the same edge, pause wins and the tick is not applied.
- PAUSED:
  - start → RUN, resuming from the held prescaler value.
  - pause and start together → remain PAUSED.
- EXPIRED:
  - Value holds at 0.0; start and pause are ignored.
  - Leave only via load or rst.
- running = (state == RUN); expired = (state == EXPIRED).
- start or pause held high for many cycles is level-tolerant: no extra transitions beyond those above.

Decomposition:
- Shared package timer_pkg holds:
  - the state enum (IDLE, RUN, PAUSED, EXPIRED);
  - TENTHS_PER_SEC = 10;
  - DEFAULT_TICK_CYCLES = 5000000.
- The stopwatch also uses DEFAULT_TICK_CYCLES for its prescale.
- One natural sub-module: tick_prescaler (enable, clear, hold → tick pulse). It is reusable by the stopwatch.

Test Plan (TICK_CYCLES=4):
- Reset then idle: rst high for 2 cycles → seconds=0, m_seconds=0, running=0, expired=0, done=0; start with value 0.0 → stays IDLE, no done pulse.
- Basic countdown: load 1.2, start → m_seconds goes 1 then 0, then seconds=0/m_seconds=9 (borrow) … down to 0.0 after 12 ticks (48 cycles) → expired=1, done high exactly 1 cycle, value stays 0.0 for 20 more cycles.
- Pause/resume: load 0.5, start, pause after 6 cycles (value 0.4, prescaler 1) → value frozen for 10 cycles; start → next decrement 3 cycles later; expire at 0.0.
- Clamping: load load_sec=1023, load_tenth=15 → seconds=999, m_seconds=9.
- Priority: load and pause and start on the same edge during RUN → new value loaded, state IDLE, running=0. pause and start together in PAUSED → stays PAUSED.
- Reset mid-run: load 5.0, start, rst asserted at cycle 7 → next cycle all outputs zero and state IDLE. In EXPIRED, start is ignored; a subsequent load 0.3 followed by start counts down again.
